// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port byte-serial memory arbiter.
// Optional alignment checking is selected with MEM_ARB_ALIGN_CHK_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    localparam int unsigned IF_BYTES_C = 4;
    localparam int unsigned DM_BYTES_C = 8;
    localparam int unsigned CNT_W      = $clog2(DM_BYTES_C + 1);

    // nbytes is a power of two, so a mask test is enough.
    function automatic logic is_misaligned(input logic [31:0] addr, input int unsigned nbytes);
        logic [31:0] mask;
        mask = nbytes - 1;
        return (addr & mask) != '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the byte-wide memory port of mem_port_arbiter.
// slave = arbiter side, master = requesters and memory model.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned IF_BYTES = 4,
    parameter int unsigned DM_BYTES = 8
);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ack;
    logic [8*IF_BYTES-1:0] if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [8*DM_BYTES-1:0] dm_wdata;
    logic                  dm_ack;
    logic [8*DM_BYTES-1:0] dm_rdata;

    logic                  err;
    logic                  busy;

    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, err, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, err, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_arb_serdes.sv
// Byte shift register: unpacks store words LSB-first and packs read bytes from the top down.
// Shared by both ports; sized for the widest (data) access.
module mem_arb_serdes
    import mem_arb_pkg::*;
#(
    parameter int unsigned NBYTES = DM_BYTES_C
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [8*NBYTES-1:0] load_data_i,
    input  logic                shift_i,
    input  logic                capture_i,
    input  logic [7:0]          cap_byte_i,
    output logic [7:0]          low_byte_o,
    output logic [8*NBYTES-1:0] data_next_o
);

    logic [8*NBYTES-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (capture_i) begin
            sr_d = {cap_byte_i, sr_q[8*NBYTES-1:8]};
        end else if (shift_i) begin
            sr_d = {8'h00, sr_q[8*NBYTES-1:8]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign low_byte_o  = sr_q[7:0];
    // Next value lets the top latch the word in the same edge as the last capture.
    assign data_next_o = sr_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one byte-wide registered-read memory.
// Define MEM_ARB_ALIGN_CHK_EN to reject misaligned accesses with err instead of wrapping.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned IF_BYTES = IF_BYTES_C,
    parameter int unsigned DM_BYTES = DM_BYTES_C
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned     CntW = $clog2(DM_BYTES + 1);
    localparam logic [CntW-1:0] IfN  = CntW'(IF_BYTES);
    localparam logic [CntW-1:0] DmN  = CntW'(DM_BYTES);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       nbytes_q, nbytes_d;
    logic [8*IF_BYTES-1:0] if_rdata_q, if_rdata_d;
    logic [8*DM_BYTES-1:0] dm_rdata_q, dm_rdata_d;
    logic                  err_q, err_d;
    logic                  pend_q, pend_d;

    logic                  req_any;
    logic                  req_mis;
    logic                  acc_re;
    logic                  acc_we;
    logic                  sd_load;
    logic                  sd_shift;
    logic                  sd_capture;
    logic [7:0]            sd_low;
    logic [8*DM_BYTES-1:0] sd_next;

    assign req_any = bus.dm_req || bus.if_req;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign req_mis = bus.dm_req ? is_misaligned(32'(bus.dm_addr), DM_BYTES)
                                : is_misaligned(32'(bus.if_addr), IF_BYTES);
`else
    assign req_mis = 1'b0;
`endif

    // READ spends N issue cycles plus one drain cycle for the registered memory read.
    assign acc_re = (state_q == READ) && (cnt_q < nbytes_q);
    assign acc_we = (state_q == WRITE);

    mem_arb_serdes #(
        .NBYTES(DM_BYTES)
    ) u_serdes (
        .clk        (clk),
        .reset      (reset),
        .load_i     (sd_load),
        .load_data_i(bus.dm_wdata),
        .shift_i    (sd_shift),
        .capture_i  (sd_capture),
        .cap_byte_i (bus.mem_rdata),
        .low_byte_o (sd_low),
        .data_next_o(sd_next)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        pend_d     = pend_q;
        sd_load    = 1'b0;
        sd_shift   = 1'b0;
        sd_capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Rejected misaligned access: answer with err and zeroed data.
                    pend_d  = 1'b0;
                    state_d = ACK;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                end else if (req_any) begin
                    owner_d  = bus.dm_req ? OWN_DM : OWN_IF;
                    addr_d   = bus.dm_req ? bus.dm_addr : bus.if_addr;
                    nbytes_d = bus.dm_req ? DmN : IfN;
                    cnt_d    = '0;
                    err_d    = req_mis;
                    if (req_mis) begin
                        pend_d = 1'b1;
                    end else if (bus.dm_req && bus.dm_we) begin
                        sd_load = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                cnt_d      = cnt_q + CntW'(1);
                sd_capture = (cnt_q != '0);
                if (acc_re) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (cnt_q == nbytes_q) begin
                    state_d = ACK;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = sd_next;
                    end else begin
                        if_rdata_d = sd_next[8*DM_BYTES-1 -: 8*IF_BYTES];
                    end
                end
            end

            WRITE: begin
                cnt_d    = cnt_q + CntW'(1);
                sd_shift = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                if (cnt_q == nbytes_q - CntW'(1)) begin
                    state_d = ACK;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            cnt_q      <= '0;
            nbytes_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        bus.mem_re    = acc_re;
        bus.mem_we    = acc_we;
        bus.mem_addr  = (acc_re || acc_we) ? addr_q : '0;
        bus.mem_wdata = acc_we ? sd_low : 8'h00;
        bus.if_ack    = (state_q == ACK) && (owner_q == OWN_IF);
        bus.dm_ack    = (state_q == ACK) && (owner_q == OWN_DM);
        bus.if_rdata  = if_rdata_q;
        bus.dm_rdata  = dm_rdata_q;
        bus.busy      = (state_q != IDLE);
`ifdef MEM_ARB_ALIGN_CHK_EN
        bus.err       = (state_q == ACK) && err_q;
`else
        bus.err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a registered-read byte memory model.
// Builds with or without MEM_ARB_ALIGN_CHK_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(
        .ADDR_W  (9),
        .IF_BYTES(4),
        .DM_BYTES(8)
    ) bus ();

    mem_port_arbiter #(
        .ADDR_W  (9),
        .IF_BYTES(4),
        .DM_BYTES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem [512];
    logic       bd_we;
    logic [8:0] bd_addr;
    logic [7:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    function automatic logic [63:0] peek8(input logic [8:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = mem[9'(a + 9'(i))];
        end
        return w;
    endfunction

    // Issues one request in cycle 0 and waits (bounded) for its ack.
    task automatic run_txn(input logic is_dm, input logic we, input logic [8:0] addr,
                           input logic [63:0] wdata, output int lat, output logic [63:0] rdata,
                           output logic errv, output int re_cnt, output logic [8:0] addr5);
        @(posedge clk);
        #1;
        if (is_dm) begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = we;
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        lat    = -1;
        rdata  = '0;
        errv   = 1'b0;
        re_cnt = 0;
        addr5  = '0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.mem_re) re_cnt++;
            if (c == 5) addr5 = bus.mem_addr;
            if (is_dm ? bus.dm_ack : bus.if_ack) begin
                lat   = c;
                rdata = is_dm ? bus.dm_rdata : {32'h0, bus.if_rdata};
                errv  = bus.err;
            end
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    int          lat;
    int          re_cnt;
    logic [63:0] rd;
    logic        ev;
    logic [8:0]  a5;

    initial begin
        reset        = 1'b1;
        bd_we        = 1'b0;
        bd_addr      = '0;
        bd_data      = '0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        poke(9'd4, 8'h83);
        poke(9'd5, 8'h00);
        poke(9'd6, 8'h01);
        poke(9'd7, 8'h00);
        for (int i = 8; i < 16; i++) poke(9'(i), 8'(i));
        for (int i = 0; i < 4; i++) poke(9'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) poke(9'h1F8 + 9'(i), 8'hF8 + 8'(i));

        @(negedge clk);
        check_eq("rst_busy", {63'h0, bus.busy}, 64'h0);
        check_eq("rst_acks", {62'h0, bus.if_ack, bus.dm_ack}, 64'h0);
        check_eq("rst_mem_ctl", {53'h0, bus.mem_re, bus.mem_we, bus.mem_addr}, 64'h0);
        check_eq("rst_rdata", bus.dm_rdata | {32'h0, bus.if_rdata}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fetch of 83 00 01 00 from byte 4.
        run_txn(1'b0, 1'b0, 9'd4, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("fetch_lat", 64'(lat), 64'd6);
        check_eq("fetch_data", rd, 64'h0000_0000_0001_0083);
        check_eq("fetch_err", {63'h0, ev}, 64'h0);
        check_eq("fetch_re_cnt", 64'(re_cnt), 64'd4);

        // Store then load at 16.
        run_txn(1'b1, 1'b1, 9'd16, 64'h0123_4567_89AB_CDEF, lat, rd, ev, re_cnt, a5);
        check_eq("store_lat", 64'(lat), 64'd9);
        check_eq("store_mem", peek8(9'd16), 64'h0123_4567_89AB_CDEF);
        run_txn(1'b1, 1'b0, 9'd16, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("load_lat", 64'(lat), 64'd10);
        check_eq("load_data", rd, 64'h0123_4567_89AB_CDEF);
        check_eq("if_rdata_hold", {32'h0, bus.if_rdata}, 64'h0001_0083);

        // Simultaneous requests: DM load at 8 first, then fetch at 4.
        begin
            int          dm_c;
            int          if_c;
            logic [63:0] dm_rd;
            logic [31:0] if_rd;
            logic [8:0]  addr12;
            logic        busy1;
            @(posedge clk);
            #1;
            bus.dm_req  = 1'b1;
            bus.dm_we   = 1'b0;
            bus.dm_addr = 9'd8;
            bus.if_req  = 1'b1;
            bus.if_addr = 9'd4;
            dm_c   = -1;
            if_c   = -1;
            dm_rd  = '0;
            if_rd  = '0;
            addr12 = '0;
            busy1  = 1'b0;
            for (int c = 0; c < 60 && (dm_c < 0 || if_c < 0); c++) begin
                @(negedge clk);
                if (c == 1) busy1 = bus.busy;
                if (c == 12) addr12 = bus.mem_addr;
                if (bus.dm_ack && dm_c < 0) begin
                    dm_c       = c;
                    dm_rd      = bus.dm_rdata;
                    bus.dm_req = 1'b0;
                end
                if (bus.if_ack && if_c < 0) begin
                    if_c       = c;
                    if_rd      = bus.if_rdata;
                    bus.if_req = 1'b0;
                end
            end
            bus.dm_req = 1'b0;
            bus.if_req = 1'b0;
            check_eq("conc_busy", {63'h0, busy1}, 64'h1);
            check_eq("conc_dm_lat", 64'(dm_c), 64'd10);
            check_eq("conc_dm_data", dm_rd, 64'h0F0E_0D0C_0B0A_0908);
            check_eq("conc_if_addr12", {55'h0, addr12}, 64'h4);
            check_eq("conc_if_lat", 64'(if_c), 64'd17);
            check_eq("conc_if_data", {32'h0, if_rd}, 64'h0001_0083);
        end

        // Aligned load at the top of memory.
        run_txn(1'b1, 1'b0, 9'h1F8, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("top_lat", 64'(lat), 64'd10);
        check_eq("top_data", rd, 64'hFFFE_FDFC_FBFA_F9F8);

`ifdef MEM_ARB_ALIGN_CHK_EN
        run_txn(1'b1, 1'b0, 9'h00C, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("mis_lat", 64'(lat), 64'd2);
        check_eq("mis_err", {63'h0, ev}, 64'h1);
        check_eq("mis_re_cnt", 64'(re_cnt), 64'd0);
        check_eq("mis_data", rd, 64'h0);
`else
        run_txn(1'b1, 1'b0, 9'h1FC, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("wrap_lat", 64'(lat), 64'd10);
        check_eq("wrap_addr5", {55'h0, a5}, 64'h0);
        check_eq("wrap_data", rd, 64'h1312_1110_FFFE_FDFC);
        run_txn(1'b1, 1'b0, 9'h00C, 64'h0, lat, rd, ev, re_cnt, a5);
        check_eq("mis_lat", 64'(lat), 64'd10);
        check_eq("mis_err", {63'h0, ev}, 64'h0);
        check_eq("mis_data", rd, 64'h89AB_CDEF_0F0E_0D0C);
`endif

        // Reset during the fourth write cycle of a store at 0.
        for (int i = 0; i < 8; i++) poke(9'(i), 8'hA0 + 8'(i));
        begin
            int acks;
            @(posedge clk);
            #1;
            bus.dm_req   = 1'b1;
            bus.dm_we    = 1'b1;
            bus.dm_addr  = 9'd0;
            bus.dm_wdata = 64'h1122_3344_5566_7788;
            repeat (4) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check_eq("rst_mid_we", {63'h0, bus.mem_we}, 64'h0);
            check_eq("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
            bus.dm_req = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            acks  = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus.dm_ack || bus.if_ack) acks++;
            end
            check_eq("rst_mid_no_ack", 64'(acks), 64'h0);
            check_eq("rst_mid_mem", peek8(9'd0), 64'hA7A6_A5A4_A366_7788);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
